// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the instruction fetch sequencer: opcodes, FSM states
// and instruction field positions.
package fetch_sequencer_pkg;

    localparam int IW_DEF = 16;
    localparam int AW_DEF = 16;

    // Opcode encodings, identical to the control decoder's table
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_BEQ  = 3'b100;
    localparam logic [2:0] OP_J    = 3'b101;
    localparam logic [2:0] OP_JR   = 3'b110;
    localparam logic [2:0] OP_JAL  = 3'b111;

    localparam int OPC_W   = 3;
    localparam int OPC_HI  = IW_DEF - 1;
    localparam int OPC_LO  = IW_DEF - OPC_W;
    localparam int FUNCT   = 0;
    localparam int JIMM_HI = 12;
    localparam int JIMM_LO = 1;
    localparam int BOFF_HI = 6;
    localparam int BOFF_LO = 1;

    typedef enum logic [1:0] {
        FETCH_REQ  = 2'd0,
        FETCH_WAIT = 2'd1,
        ISSUE      = 2'd2,
        MEM_HOLD   = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_sequencer_next_pc_calc.sv
// Combinational next-PC selection: jr > jump > taken branch > sequential.
module next_pc_calc
    import fetch_sequencer_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic [AW-1:0]                pc,
    input  logic [JIMM_HI-JIMM_LO:0]     jimm,
    input  logic [BOFF_HI-BOFF_LO:0]     boff,
    input  logic                         jrctrl,
    input  logic                         jctrl,
    input  logic                         beqctrl,
    input  logic                         alu_zero,
    input  logic [AW-1:0]                jr_target,
    output logic [AW-1:0]                next_pc
);

    logic [AW-1:0] seq_pc;
    logic [AW-1:0] jimm_ext;
    logic [AW-1:0] boff_ext;

    assign seq_pc   = pc + AW'(1);
    assign jimm_ext = AW'(jimm);
    assign boff_ext = AW'($signed(boff));

    // All arithmetic is AW bits wide so wrap-around falls out naturally
    always_comb begin
        next_pc = seq_pc;
        if (jrctrl) begin
            next_pc = jr_target;
        end else if (jctrl) begin
            next_pc = jimm_ext;
        end else if (beqctrl && alu_zero) begin
            next_pc = seq_pc + boff_ext;
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the PC, fetches over req/gnt/rvalid and
// presents opcode/funct/word to the decoder with registered outputs.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int IW = IW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_gnt,
    input  logic          imem_rvalid,
    input  logic [IW-1:0] imem_rdata,
    output logic [2:0]    inst1,
    output logic          inst2,
    output logic [IW-1:0] inst_word,
    output logic          inst_valid,
    output logic [AW-1:0] pc_plus1,
    input  logic          jctrl,
    input  logic          jrctrl,
    input  logic          beqctrl,
    input  logic          memctrl,
    input  logic          alu_zero,
    input  logic [AW-1:0] jr_target,
    input  logic          stall_in
);

    fetch_state_e  state_reg;
    logic [AW-1:0] pc_reg;
    logic [AW-1:0] pc_plus1_reg;
    logic [AW-1:0] next_pc;
    logic          imem_req_reg;
    logic          inst_valid_reg;
    logic [2:0]    inst1_reg;
    logic          inst2_reg;
    logic [IW-1:0] inst_word_reg;

    next_pc_calc #(.AW(AW)) u_next_pc (
        .pc        (pc_reg),
        .jimm      (inst_word_reg[JIMM_HI:JIMM_LO]),
        .boff      (inst_word_reg[BOFF_HI:BOFF_LO]),
        .jrctrl    (jrctrl),
        .jctrl     (jctrl),
        .beqctrl   (beqctrl),
        .alu_zero  (alu_zero),
        .jr_target (jr_target),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= FETCH_REQ;
            pc_reg         <= '0;
            pc_plus1_reg   <= AW'(1);
            imem_req_reg   <= 1'b0;
            inst_valid_reg <= 1'b0;
            inst1_reg      <= OP_ADD;
            inst2_reg      <= 1'b0;
            inst_word_reg  <= '0;
        end else begin
            case (state_reg)
                // req is raised one cycle into the state and dropped on the grant
                FETCH_REQ: begin
                    if (imem_req_reg && imem_gnt) begin
                        imem_req_reg <= 1'b0;
                        state_reg    <= FETCH_WAIT;
                    end else begin
                        imem_req_reg <= 1'b1;
                    end
                end
                FETCH_WAIT: begin
                    if (imem_rvalid) begin
                        inst_word_reg  <= imem_rdata;
                        inst1_reg      <= imem_rdata[IW-1 -: OPC_W];
                        inst2_reg      <= imem_rdata[FUNCT];
                        inst_valid_reg <= 1'b1;
                        state_reg      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!stall_in) begin
                        pc_reg       <= next_pc;
                        pc_plus1_reg <= next_pc + AW'(1);
                        if (memctrl) begin
                            state_reg <= MEM_HOLD;
                        end else begin
                            state_reg      <= FETCH_REQ;
                            imem_req_reg   <= 1'b1;
                            inst_valid_reg <= 1'b0;
                            inst1_reg      <= OP_ADD;
                            inst2_reg      <= 1'b0;
                        end
                    end
                end
                MEM_HOLD: begin
                    state_reg      <= FETCH_REQ;
                    imem_req_reg   <= 1'b1;
                    inst_valid_reg <= 1'b0;
                    inst1_reg      <= OP_ADD;
                    inst2_reg      <= 1'b0;
                end
                default: state_reg <= FETCH_REQ;
            endcase
        end
    end

    assign imem_req   = imem_req_reg;
    assign imem_addr  = pc_reg;
    assign inst1      = inst1_reg;
    assign inst2      = inst2_reg;
    assign inst_word  = inst_word_reg;
    assign inst_valid = inst_valid_reg;
    assign pc_plus1   = pc_plus1_reg;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench for fetch_sequencer against an arithmetic
// next-PC model and an idealised memory responder.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [15:0] imem_rdata;
    logic [2:0]  inst1;
    logic        inst2;
    logic [15:0] inst_word;
    logic        inst_valid;
    logic [15:0] pc_plus1;
    logic        jctrl, jrctrl, beqctrl, memctrl, alu_zero, stall_in;
    logic [15:0] jr_target;

    int checks = 0;
    int errors = 0;
    int model_pc = 0;

    // observations from the last fetch
    logic [15:0] obs_addr, obs_word, obs_pc_plus1, obs_next_addr;
    logic [2:0]  obs_inst1;
    logic        obs_inst2, obs_valid, obs_next_req, obs_after_valid;
    bit          obs_addr_stable, obs_req_dropped, obs_idle_ok;
    bit          obs_stall_stable, obs_hold, obs_hold_ok;

    fetch_sequencer #(.IW(16), .AW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst1(inst1), .inst2(inst2), .inst_word(inst_word), .inst_valid(inst_valid),
        .pc_plus1(pc_plus1),
        .jctrl(jctrl), .jrctrl(jrctrl), .beqctrl(beqctrl), .memctrl(memctrl),
        .alu_zero(alu_zero), .jr_target(jr_target), .stall_in(stall_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    function automatic int ref_next(int pc, logic [15:0] w, bit jr, bit j, bit beq, bit zero, int jrt);
        int off;
        if (jr) return jrt;
        if (j) return (int'(w) >> 1) & 4095;
        if (beq && zero) begin
            off = (int'(w) >> 1) & 63;
            if (off >= 32) off = off - 64;
            return (pc + 1 + off + 65536) % 65536;
        end
        return (pc + 1) % 65536;
    endfunction

    function automatic logic [15:0] mk_word(logic [2:0] opc, logic [12:0] low);
        logic [15:0] w;
        w = {3'b000, low};
        w[OPC_HI:OPC_LO] = opc;
        return w;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_pc = 0;
    endtask

    // Runs one full fetch/issue from FETCH_REQ, recording what the DUT showed.
    task automatic do_fetch(input logic [15:0] word, input int gnt_dly, input int rv_dly,
                            input int stall_n, input bit jr, input bit j, input bit beq,
                            input bit mem, input bit zero, input logic [15:0] jrt);
        int n;
        n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 20) begin
            errors++;
            $display("FAIL req_timeout got req=%b exp req=1", imem_req);
        end
        obs_addr = imem_addr;
        obs_addr_stable = 1'b1;
        repeat (gnt_dly) begin
            @(negedge clk);
            if (imem_req !== 1'b1 || imem_addr !== obs_addr) obs_addr_stable = 1'b0;
        end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        obs_req_dropped = (imem_req === 1'b0);
        obs_idle_ok = (inst_valid === 1'b0 && inst1 === 3'b000 && inst2 === 1'b0);
        repeat (rv_dly) begin
            @(negedge clk);
            if (inst_valid !== 1'b0 || inst1 !== 3'b000) obs_idle_ok = 1'b0;
        end
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        @(negedge clk);
        imem_rvalid = 1'b0;
        imem_rdata  = 16'($urandom);
        obs_valid = inst_valid;
        obs_inst1 = inst1;
        obs_inst2 = inst2;
        obs_word  = inst_word;
        obs_pc_plus1 = pc_plus1;
        jrctrl = jr; jctrl = j; beqctrl = beq; memctrl = mem; alu_zero = zero; jr_target = jrt;
        stall_in = (stall_n > 0);
        obs_stall_stable = 1'b1;
        for (int k = 0; k < stall_n; k++) begin
            @(negedge clk);
            if (inst_valid !== 1'b1 || inst_word !== obs_word || inst1 !== obs_inst1 ||
                inst2 !== obs_inst2 || pc_plus1 !== obs_pc_plus1 || imem_addr !== obs_addr ||
                imem_req !== 1'b0)
                obs_stall_stable = 1'b0;
            if (k == stall_n - 1) stall_in = 1'b0;
        end
        @(negedge clk);
        jrctrl = 0; jctrl = 0; beqctrl = 0; memctrl = 0; alu_zero = 0;
        obs_hold = 1'b0;
        obs_hold_ok = 1'b1;
        if (inst_valid === 1'b1) begin
            obs_hold = 1'b1;
            obs_hold_ok = (inst_word === obs_word && inst1 === obs_inst1 && inst2 === obs_inst2);
            @(negedge clk);
        end
        obs_after_valid = inst_valid;
        obs_next_req  = imem_req;
        obs_next_addr = imem_addr;
    endtask

    task automatic goto_pc(input int target);
        do_fetch(16'h0000, 0, 0, 0, 1, 0, 0, 0, 0, 16'(target));
        model_pc = target;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({imem_req, inst_valid, inst1, inst2} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got req=%b valid=%b inst1=%b inst2=%b exp all 0",
                     imem_req, inst_valid, inst1, inst2);
        end
        checks++;
        if (inst_word !== 16'h0 || pc_plus1 !== 16'h1 || imem_addr !== 16'h0) begin
            errors++;
            $display("FAIL reset_data got word=%h pc_plus1=%h addr=%h exp 0000/0001/0000",
                     inst_word, pc_plus1, imem_addr);
        end
        rst_n = 1'b1;
        checks++;
        if (imem_req !== 1'b0) begin
            errors++;
            $display("FAIL req_before_edge got %b exp 0", imem_req);
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1) begin
            errors++;
            $display("FAIL req_after_release got %b exp 1", imem_req);
        end
        model_pc = 0;
    endtask

    task automatic test_first_fetch();
        do_fetch(16'h0001, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        checks++;
        if (obs_addr !== 16'h0 || obs_valid !== 1'b1) begin
            errors++;
            $display("FAIL first_fetch got addr=%h valid=%b exp 0000/1", obs_addr, obs_valid);
        end
        checks++;
        if (obs_inst1 !== 3'b000 || obs_inst2 !== 1'b1 || obs_word !== 16'h0001) begin
            errors++;
            $display("FAIL first_fields got inst1=%b inst2=%b word=%h exp 000/1/0001",
                     obs_inst1, obs_inst2, obs_word);
        end
        checks++;
        if (!obs_req_dropped || !obs_idle_ok) begin
            errors++;
            $display("FAIL first_handshake got dropped=%0d idle=%0d exp 1/1", obs_req_dropped, obs_idle_ok);
        end
        checks++;
        if (obs_next_req !== 1'b1 || obs_next_addr !== 16'h1 || obs_after_valid !== 1'b0) begin
            errors++;
            $display("FAIL first_next got req=%b addr=%h valid=%b exp 1/0001/0",
                     obs_next_req, obs_next_addr, obs_after_valid);
        end
        model_pc = 1;
    endtask

    task automatic test_sequential();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            do_fetch(mk_word(OP_ADD, 13'($urandom)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, 2)), 0, 0, 0, 0, 0, 0, 16'h0);
            checks++;
            if (obs_addr !== 16'(i) || obs_pc_plus1 !== 16'(i + 1) || !obs_addr_stable) begin
                errors++;
                $display("FAIL seq_%0d got addr=%h pc_plus1=%h stable=%0d exp %h/%h/1",
                         i, obs_addr, obs_pc_plus1, obs_addr_stable, 16'(i), 16'(i + 1));
            end
            model_pc = i + 1;
        end
        checks++;
        if (obs_next_addr !== 16'h3) begin
            errors++;
            $display("FAIL seq_next got %h exp 0003", obs_next_addr);
        end
    endtask

    task automatic test_beq();
        logic [15:0] w;
        bit zero_v [3] = '{1'b1, 1'b0, 1'b1};
        int start_v [3] = '{4, 4, 0};
        int off_v   [3] = '{3, 3, 63};
        int exp_v   [3] = '{8, 5, 0};
        for (int i = 0; i < 3; i++) begin
            goto_pc(start_v[i]);
            w = mk_word(OP_BEQ, 13'(off_v[i] << 1));
            do_fetch(w, 0, 1, 0, 0, 0, 1, 0, zero_v[i], 16'($urandom));
            checks++;
            if (obs_addr !== 16'(start_v[i]) || obs_next_addr !== 16'(exp_v[i])) begin
                errors++;
                $display("FAIL beq_%0d got addr=%h next=%h exp %h/%h",
                         i, obs_addr, obs_next_addr, 16'(start_v[i]), 16'(exp_v[i]));
            end
            model_pc = exp_v[i];
        end
    endtask

    task automatic test_jump();
        goto_pc(16);
        do_fetch(mk_word(OP_JAL, 13'(12'h020 << 1)), 1, 0, 0, 0, 1, 0, 0, 0, 16'h7777);
        checks++;
        if (obs_pc_plus1 !== 16'h0011 || obs_next_addr !== 16'h0020 || obs_inst1 !== OP_JAL) begin
            errors++;
            $display("FAIL jal got pc_plus1=%h next=%h inst1=%b exp 0011/0020/%b",
                     obs_pc_plus1, obs_next_addr, obs_inst1, OP_JAL);
        end
        do_fetch(mk_word(OP_JR, 13'h0), 0, 0, 0, 1, 0, 0, 0, 0, 16'h0011);
        checks++;
        if (obs_addr !== 16'h0020 || obs_next_addr !== 16'h0011) begin
            errors++;
            $display("FAIL jr got addr=%h next=%h exp 0020/0011", obs_addr, obs_next_addr);
        end
        do_fetch(mk_word(OP_J, 13'(12'h0AB << 1)), 0, 0, 0, 1, 1, 1, 0, 1, 16'h1234);
        checks++;
        if (obs_next_addr !== 16'h1234) begin
            errors++;
            $display("FAIL jr_over_j got %h exp 1234", obs_next_addr);
        end
        model_pc = 16'h1234;
    endtask

    task automatic test_mem_stall();
        do_fetch(mk_word(OP_LW, 13'h5), 0, 0, 0, 0, 0, 0, 1, 0, 16'h0);
        checks++;
        if (!obs_hold || !obs_hold_ok || obs_after_valid !== 1'b0 || obs_next_req !== 1'b1) begin
            errors++;
            $display("FAIL mem_hold got hold=%0d ok=%0d valid_after=%b req=%b exp 1/1/0/1",
                     obs_hold, obs_hold_ok, obs_after_valid, obs_next_req);
        end
        checks++;
        if (obs_next_addr !== 16'(model_pc + 1)) begin
            errors++;
            $display("FAIL mem_next got %h exp %h", obs_next_addr, 16'(model_pc + 1));
        end
        model_pc = model_pc + 1;
        do_fetch(mk_word(OP_ADD, 13'h1), 0, 0, 4, 0, 0, 0, 0, 0, 16'h0);
        checks++;
        if (!obs_stall_stable || obs_hold || obs_next_addr !== 16'(model_pc + 1)) begin
            errors++;
            $display("FAIL stall got stable=%0d hold=%0d next=%h exp 1/0/%h",
                     obs_stall_stable, obs_hold, obs_next_addr, 16'(model_pc + 1));
        end
        model_pc = model_pc + 1;
    endtask

    task automatic test_wrap();
        goto_pc(16'hFFFF);
        do_fetch(mk_word(OP_ADD, 13'h0), 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        checks++;
        if (obs_addr !== 16'hFFFF || obs_pc_plus1 !== 16'h0000 || obs_next_addr !== 16'h0000) begin
            errors++;
            $display("FAIL wrap got addr=%h pc_plus1=%h next=%h exp FFFF/0000/0000",
                     obs_addr, obs_pc_plus1, obs_next_addr);
        end
        model_pc = 0;
    endtask

    task automatic test_reset_midflight();
        goto_pc(16'h0055);
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b0 || inst_valid !== 1'b0 || imem_addr !== 16'h0) begin
            errors++;
            $display("FAIL async_reset got req=%b valid=%b addr=%h exp 0/0/0000",
                     imem_req, inst_valid, imem_addr);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imem_rvalid = 1'b1;
        imem_rdata  = 16'hFFFF;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++;
        if (inst_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0) begin
            errors++;
            $display("FAIL stale_rvalid got valid=%b req=%b addr=%h exp 0/1/0000",
                     inst_valid, imem_req, imem_addr);
        end
        model_pc = 0;
        do_fetch(16'h2001, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0);
        checks++;
        if (obs_addr !== 16'h0 || obs_word !== 16'h2001 || obs_next_addr !== 16'h1) begin
            errors++;
            $display("FAIL post_reset got addr=%h word=%h next=%h exp 0000/2001/0001",
                     obs_addr, obs_word, obs_next_addr);
        end
        model_pc = 1;
    endtask

    task automatic test_random();
        logic [15:0] w, jrt;
        bit jr, j, beq, zero, mem;
        int exp_next, stall_n;
        for (int it = 0; it < 40; it++) begin
            w    = 16'($urandom);
            jrt  = 16'($urandom);
            jr   = ($urandom_range(0, 5) == 0);
            j    = ($urandom_range(0, 4) == 0);
            beq  = ($urandom_range(0, 2) == 0);
            zero = 1'($urandom);
            mem  = ($urandom_range(0, 3) == 0);
            stall_n = int'($urandom_range(0, 2));
            exp_next = ref_next(model_pc, w, jr, j, beq, zero, int'(jrt));
            do_fetch(w, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), stall_n,
                     jr, j, beq, mem, zero, jrt);
            checks++;
            if (obs_addr !== 16'(model_pc) || obs_pc_plus1 !== 16'((model_pc + 1) % 65536) ||
                obs_valid !== 1'b1 || !obs_addr_stable || !obs_req_dropped || !obs_idle_ok) begin
                errors++;
                $display("FAIL rnd_fetch_%0d got addr=%h pc_plus1=%h valid=%b hs=%0d%0d%0d exp %h/%h/1/111",
                         it, obs_addr, obs_pc_plus1, obs_valid, obs_addr_stable, obs_req_dropped,
                         obs_idle_ok, 16'(model_pc), 16'((model_pc + 1) % 65536));
            end
            checks++;
            if (obs_word !== w || obs_inst1 !== w[OPC_HI:OPC_LO] || obs_inst2 !== w[FUNCT] ||
                !obs_stall_stable) begin
                errors++;
                $display("FAIL rnd_fields_%0d got word=%h inst1=%b inst2=%b stable=%0d exp %h/%b/%b/1",
                         it, obs_word, obs_inst1, obs_inst2, obs_stall_stable, w,
                         w[OPC_HI:OPC_LO], w[FUNCT]);
            end
            checks++;
            if (obs_hold !== mem || !obs_hold_ok || obs_next_req !== 1'b1 ||
                obs_next_addr !== 16'(exp_next)) begin
                errors++;
                $display("FAIL rnd_next_%0d got hold=%0d next=%h req=%b exp hold=%0d next=%h req=1",
                         it, obs_hold, obs_next_addr, obs_next_req, mem, 16'(exp_next));
            end
            model_pc = exp_next;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        jctrl = 0; jrctrl = 0; beqctrl = 0; memctrl = 0; alu_zero = 0; stall_in = 0;
        jr_target = '0;
        test_reset();
        test_first_fetch();
        test_sequential();
        test_beq();
        test_jump();
        test_mem_stall();
        test_wrap();
        test_reset_midflight();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
